// File: rtl/mesa_pkg.sv
// Shared Mesa-Bus constants: byte/counter widths, the default forced-release
// timeout, and the transmit arbiter state encodings.
package mesa_pkg;

  localparam int          MESA_BYTE_W          = 8;
  localparam int          MESA_CNT_W           = 16;
  localparam logic [15:0] MESA_TIMEOUT_DEFAULT = 16'd50000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/mesa_idle_cnt.sv
// Saturating idle-cycle counter used to detect a requester that holds the
// channel without sending anything.
module mesa_idle_cnt
  import mesa_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_inc,
  output logic [MESA_CNT_W-1:0] o_count
);

  logic [MESA_CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + MESA_CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mesa_tx_arb.sv
// Two-requester arbiter in front of the byte-to-ASCII converter. Grants one
// requester per packet, alternates on contention, and force-releases idle owners.
module mesa_tx_arb
  import mesa_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = MESA_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_req,
  input  logic                   a_byte_en,
  input  logic [MESA_BYTE_W-1:0] a_byte_d,
  input  logic                   a_done,
  output logic                   a_busy,
  output logic                   a_gnt,
  input  logic                   b_req,
  input  logic                   b_byte_en,
  input  logic [MESA_BYTE_W-1:0] b_byte_d,
  input  logic                   b_done,
  output logic                   b_busy,
  output logic                   b_gnt,
  output logic                   tx_byte_en,
  output logic [MESA_BYTE_W-1:0] tx_byte_d,
  input  logic                   tx_byte_busy,
  output logic                   tx_byte_done,
  output logic                   timeout_err,
  output arb_state_t             o_state
);

  // Handshake: a requester may strobe x_byte_en only while x_gnt=1 and x_busy=0;
  // the strobe and byte pass straight through, so tx_byte_busy is the only backpressure.
  arb_state_t            r_state;
  req_id_t               r_last;
  req_id_t               r_cur;
  logic                  r_timeout_err;
  logic [MESA_CNT_W-1:0] w_idle_cnt;
  logic                  w_in_gnt;
  logic                  w_sel_b;
  logic                  w_x_en;
  logic                  w_x_done;
  logic [MESA_BYTE_W-1:0] w_x_d;
  logic                  w_timeout;
  logic                  w_release;

  assign w_in_gnt  = (r_state == ST_GNT_A) || (r_state == ST_GNT_B);
  assign w_sel_b   = (r_state == ST_GNT_B);
  assign w_x_en    = w_in_gnt && (w_sel_b ? b_byte_en : a_byte_en);
  assign w_x_done  = w_in_gnt && (w_sel_b ? b_done : a_done);
  assign w_x_d     = w_sel_b ? b_byte_d : a_byte_d;
  assign w_timeout = w_in_gnt && !w_x_en && !w_x_done && (w_idle_cnt == (TIMEOUT - 16'd1));
  assign w_release = w_x_done || w_timeout;

  mesa_idle_cnt u_idle_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clear (!w_in_gnt || w_x_en),
    .i_inc   (w_in_gnt),
    .o_count (w_idle_cnt)
  );

  always_comb begin
    a_busy       = 1'b1;
    b_busy       = 1'b1;
    tx_byte_en   = w_x_en;
    tx_byte_d    = '0;
    // A reset landing mid-packet abandons it without an end-of-packet pulse.
    tx_byte_done = w_release && !reset;
    if (w_in_gnt) begin
      tx_byte_d = w_x_d;
      if (w_sel_b) b_busy = tx_byte_busy;
      else         a_busy = tx_byte_busy;
    end
  end

  assign a_gnt       = (r_state == ST_GNT_A);
  assign b_gnt       = (r_state == ST_GNT_B);
  assign timeout_err = r_timeout_err;
  assign o_state     = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_last        <= REQ_B;
      r_cur         <= REQ_A;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (a_req && (!b_req || (r_last == REQ_B))) begin
            r_state <= ST_GNT_A;
            r_cur   <= REQ_A;
          end else if (b_req) begin
            r_state <= ST_GNT_B;
            r_cur   <= REQ_B;
          end
        end
        ST_GNT_A, ST_GNT_B: begin
          if (w_release) r_state <= ST_DRAIN;
          if (w_timeout) r_timeout_err <= 1'b1;
        end
        ST_DRAIN: begin
          if (!tx_byte_busy) begin
            r_state <= ST_IDLE;
            r_last  <= r_cur;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesa_tx_arb.sv
// Bench for mesa_tx_arb: vector table, directed corner sequences, and random
// traffic against a packet-level reference model with a byte scoreboard.
module tb_mesa_tx_arb;
  import mesa_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_byte_en, a_done, b_req, b_byte_en, b_done;
  logic [7:0] a_byte_d, b_byte_d;
  logic       a_busy, a_gnt, b_busy, b_gnt;
  logic       tx_byte_en, tx_byte_busy, tx_byte_done, timeout_err;
  logic [7:0] tx_byte_d;
  arb_state_t o_state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  // model: owner 0=none 1=A 2=B; drain marks the post-packet wait
  int m_owner;
  bit m_drain;
  int m_idle;
  bit m_last_b;
  bit m_err;

  logic s_a_gnt, s_b_gnt, s_a_busy, s_b_busy, s_en, s_done, s_err;
  logic [7:0] s_d;
  arb_state_t s_state;

  mesa_tx_arb #(.TIMEOUT(16'(TO))) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_byte_en(a_byte_en), .a_byte_d(a_byte_d), .a_done(a_done),
    .a_busy(a_busy), .a_gnt(a_gnt),
    .b_req(b_req), .b_byte_en(b_byte_en), .b_byte_d(b_byte_d), .b_done(b_done),
    .b_busy(b_busy), .b_gnt(b_gnt),
    .tx_byte_en(tx_byte_en), .tx_byte_d(tx_byte_d), .tx_byte_busy(tx_byte_busy),
    .tx_byte_done(tx_byte_done), .timeout_err(timeout_err), .o_state(o_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    reset = 1'b0; a_req = 1'b0; a_byte_en = 1'b0; a_byte_d = 8'h00; a_done = 1'b0;
    b_req = 1'b0; b_byte_en = 1'b0; b_byte_d = 8'h00; b_done = 1'b0; tx_byte_busy = 1'b0;
  endtask

  // One clock: called just after a falling edge with inputs set; checks outputs
  // against the model, advances the model, and returns at the next falling edge.
  task automatic cyc();
    bit granted, sel_b, x_en, x_done, tmo;
    logic [7:0] x_d;
    #1;
    granted = (m_owner != 0) && !m_drain;
    sel_b   = (m_owner == 2);
    x_en    = granted && (sel_b ? b_byte_en : a_byte_en);
    x_done  = granted && (sel_b ? b_done : a_done);
    x_d     = sel_b ? b_byte_d : a_byte_d;
    tmo     = granted && !x_en && !x_done && (m_idle == TO - 1);
    s_a_gnt = a_gnt; s_b_gnt = b_gnt; s_a_busy = a_busy; s_b_busy = b_busy;
    s_en = tx_byte_en; s_d = tx_byte_d; s_done = tx_byte_done; s_err = timeout_err;
    s_state = o_state;
    check("a_gnt", a_gnt, granted && !sel_b);
    check("b_gnt", b_gnt, granted && sel_b);
    check("a_busy", a_busy, (granted && !sel_b) ? tx_byte_busy : 1'b1);
    check("b_busy", b_busy, (granted && sel_b) ? tx_byte_busy : 1'b1);
    check("tx_en", tx_byte_en, x_en);
    check("tx_d", tx_byte_d, granted ? x_d : 8'h00);
    check("tx_done", tx_byte_done, (x_done || tmo) && !reset);
    check("t_err", timeout_err, m_err);
    if (x_en) exp_q.push_back(x_d);
    if (tx_byte_en === 1'b1) begin
      if (exp_q.size() == 0) check("sb_unexpected_byte", tx_byte_d, 8'h00 ^ 8'hFF ^ tx_byte_d ^ 8'hFF);
      else check("sb_byte", tx_byte_d, exp_q.pop_front());
    end
    if (reset) begin
      m_owner = 0; m_drain = 0; m_idle = 0; m_last_b = 1; m_err = 0;
    end else if (m_owner == 0) begin
      if (a_req && (!b_req || m_last_b)) m_owner = 1;
      else if (b_req) m_owner = 2;
      m_idle = 0;
    end else if (!m_drain) begin
      if (x_done || tmo) m_drain = 1;
      if (tmo) m_err = 1;
      m_idle = x_en ? 0 : ((m_idle < 65535) ? m_idle + 1 : m_idle);
    end else if (!tx_byte_busy) begin
      m_last_b = sel_b;
      m_owner = 0;
      m_drain = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  typedef struct {
    logic rst, a_req, a_en; logic [7:0] a_d; logic a_done;
    logic b_req, b_en; logic [7:0] b_d; logic b_done, busy;
    logic e_a_gnt, e_b_gnt, e_a_busy, e_b_busy, e_en; logic [7:0] e_d; logic e_done, e_err;
  } vec_t;

  vec_t vt[18];

  initial begin
    int drain_cnt, gnt_cnt;
    bit done_seen;
    // rst a_req a_en a_d a_done b_req b_en b_d b_done busy | agnt bgnt abusy bbusy en d done err
    vt[0]  = '{1,0,0,8'h00,0, 0,0,8'h00,0,0,  0,0,1,1,0,8'h00,0,0};
    vt[1]  = '{0,1,0,8'h00,0, 0,0,8'h00,0,0,  0,0,1,1,0,8'h00,0,0};
    vt[2]  = '{0,1,1,8'hF0,0, 0,0,8'h00,0,0,  1,0,0,1,1,8'hF0,0,0};
    vt[3]  = '{0,1,1,8'h0F,0, 0,0,8'h00,0,0,  1,0,0,1,1,8'h0F,0,0};
    vt[4]  = '{0,1,0,8'h33,0, 0,0,8'h00,0,1,  1,0,1,1,0,8'h33,0,0};
    vt[5]  = '{0,1,1,8'h55,0, 0,0,8'h00,0,0,  1,0,0,1,1,8'h55,0,0};
    vt[6]  = '{0,1,0,8'h00,1, 0,0,8'h00,0,1,  1,0,1,1,0,8'h00,1,0};
    vt[7]  = '{0,0,0,8'h00,0, 0,0,8'h00,0,1,  0,0,1,1,0,8'h00,0,0};
    vt[8]  = '{0,0,0,8'h00,0, 0,0,8'h00,0,0,  0,0,1,1,0,8'h00,0,0};
    vt[9]  = '{0,0,0,8'h00,0, 1,0,8'h00,0,0,  0,0,1,1,0,8'h00,0,0};
    vt[10] = '{0,0,1,8'hAA,0, 1,1,8'h3C,0,0,  0,1,1,0,1,8'h3C,0,0};
    vt[11] = '{0,1,1,8'hAA,0, 1,0,8'h00,0,1,  0,1,1,1,0,8'h00,0,0};
    vt[12] = '{0,1,1,8'hAA,0, 1,0,8'h00,1,0,  0,1,1,0,0,8'h00,1,0};
    vt[13] = '{0,1,0,8'h00,0, 0,0,8'h00,0,0,  0,0,1,1,0,8'h00,0,0};
    vt[14] = '{0,1,0,8'h00,0, 0,0,8'h00,0,0,  0,0,1,1,0,8'h00,0,0};
    vt[15] = '{0,1,1,8'h77,1, 0,0,8'h00,0,0,  1,0,0,1,1,8'h77,1,0};
    vt[16] = '{0,0,0,8'h00,0, 0,0,8'h00,0,0,  0,0,1,1,0,8'h00,0,0};
    vt[17] = '{0,0,0,8'h00,0, 0,0,8'h00,0,0,  0,0,1,1,0,8'h00,0,0};

    clear_inputs();
    reset = 1'b1;
    m_owner = 0; m_drain = 0; m_idle = 0; m_last_b = 1; m_err = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 18; i++) begin
      reset = vt[i].rst; a_req = vt[i].a_req; a_byte_en = vt[i].a_en; a_byte_d = vt[i].a_d;
      a_done = vt[i].a_done; b_req = vt[i].b_req; b_byte_en = vt[i].b_en; b_byte_d = vt[i].b_d;
      b_done = vt[i].b_done; tx_byte_busy = vt[i].busy;
      cyc();
      check($sformatf("vec%0d_a_gnt", i), s_a_gnt, vt[i].e_a_gnt);
      check($sformatf("vec%0d_b_gnt", i), s_b_gnt, vt[i].e_b_gnt);
      check($sformatf("vec%0d_a_busy", i), s_a_busy, vt[i].e_a_busy);
      check($sformatf("vec%0d_b_busy", i), s_b_busy, vt[i].e_b_busy);
      check($sformatf("vec%0d_en", i), s_en, vt[i].e_en);
      check($sformatf("vec%0d_d", i), s_d, vt[i].e_d);
      check($sformatf("vec%0d_done", i), s_done, vt[i].e_done);
      check($sformatf("vec%0d_err", i), s_err, vt[i].e_err);
    end

    // contention alternates A, B, A
    do_reset();
    a_req = 1; b_req = 1;
    cyc();
    cyc();
    check("alt1_a_gnt", s_a_gnt, 1); check("alt1_b_gnt", s_b_gnt, 0);
    a_done = 1; cyc(); a_done = 0; a_req = 0;
    cyc();
    cyc();
    cyc();
    check("alt2_b_gnt", s_b_gnt, 1); check("alt2_a_gnt", s_a_gnt, 0);
    b_done = 1; a_req = 1; cyc(); b_done = 0;
    cyc();
    cyc();
    cyc();
    check("alt3_a_gnt", s_a_gnt, 1); check("alt3_b_gnt", s_b_gnt, 0);

    // converter busy holds DRAIN; B waits
    do_reset();
    a_req = 1; cyc();
    a_done = 1; tx_byte_busy = 1; cyc();
    a_done = 0; a_req = 0; b_req = 1;
    drain_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (s_state == ST_DRAIN) drain_cnt++;
      check("drain_b_gnt_low", s_b_gnt, 0);
    end
    check("drain_cycles", drain_cnt, 20);
    tx_byte_busy = 0; cyc();
    cyc();
    cyc();
    check("after_drain_b_gnt", s_b_gnt, 1);

    // idle timeout
    do_reset();
    a_req = 1; cyc();
    gnt_cnt = 0; done_seen = 0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      cyc();
      if (s_a_gnt) gnt_cnt++;
      if (s_done) done_seen = 1;
    end
    check("tmo_pulse_seen", done_seen, 1);
    check("tmo_cycles", gnt_cnt, TO);
    a_req = 0; cyc();
    check("tmo_err_set", s_err, 1);
    b_req = 1; b_byte_en = 1; b_byte_d = 8'h5A;
    repeat (4) cyc();
    b_byte_en = 0; b_done = 1; cyc(); b_done = 0; b_req = 0;
    cyc();
    check("tmo_err_sticky", s_err, 1);
    do_reset();
    cyc();
    check("tmo_err_cleared", s_err, 0);

    // reset in the middle of a B packet
    do_reset();
    b_req = 1; cyc();
    b_byte_en = 1; b_byte_d = 8'h42; cyc();
    check("mid_b_gnt", s_b_gnt, 1);
    b_byte_en = 0; reset = 1; cyc();
    check("mid_rst_no_done", s_done, 0);
    reset = 0; cyc();
    check("mid_state_idle", s_state, ST_IDLE);
    check("mid_a_gnt", s_a_gnt, 0); check("mid_b_gnt0", s_b_gnt, 0);
    check("mid_a_busy", s_a_busy, 1); check("mid_b_busy", s_b_busy, 1);
    check("mid_en", s_en, 0); check("mid_d", s_d, 0); check("mid_done", s_done, 0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      reset        = ($urandom_range(0, 399) == 0);
      a_req        = ($urandom_range(0, 3) != 0);
      a_byte_en    = ($urandom_range(0, 7) == 0);
      a_byte_d     = 8'($urandom_range(0, 255));
      a_done       = ($urandom_range(0, 19) == 0);
      b_req        = ($urandom_range(0, 3) != 0);
      b_byte_en    = ($urandom_range(0, 7) == 0);
      b_byte_d     = 8'($urandom_range(0, 255));
      b_done       = ($urandom_range(0, 19) == 0);
      tx_byte_busy = ($urandom_range(0, 2) == 0);
      cyc();
    end
    clear_inputs();
    cyc();
    check("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
